spi_regfile_responder: RTL and testbench
========================================

Name: spi_regfile_responder

Overview:
- SPI mode-0 responder (target) that sits at the far end of the SoC's SPI master pins (spi_SCLK/spi_MOSI/spi_SS_n in, spi_MISO out).
- Exposes a 32 x 8-bit register file, so the soft CPU's SPI/USB driver path can be exercised and debugged in fabric without a USB chip attached.
- Command-byte format is MAX3421E-style: register address in cmd[7:3], write flag in cmd[1].
- FPGA logic gets a second register-file port, plus a write-event pulse for each register the SPI master writes.

Parameters:
- ADDR_W, 5, register address width; register count is 2**ADDR_W.
- STAT_REG, 0, address of the register shifted out on MISO during the command byte.
- SYNC_STAGES, 2, synchronizer depth for SCLK, MOSI and SS_n (minimum 2).

Ports:
- clk_clk  input  1  system clock; must be at least 8x the SCLK frequency.
- reset_reset_n  input  1  asynchronous, active-low reset.
- spi_SCLK  input  1  SPI clock from the master; idles low (mode 0).
- spi_MOSI  input  1  master-out data, MSB first.
- spi_SS_n  input  1  active-low select.
- spi_MISO  output  1  responder data, MSB first.
- host_addr  input  ADDR_W  FPGA-side register address.
- host_wdata  input  8  FPGA-side write data.
- host_we  input  1  FPGA-side write strobe.
- host_rdata  output  8  registered read of regs[host_addr].
- spi_wr_pulse  output  1  one-cycle strobe when an SPI write commits.
- spi_wr_addr  output  ADDR_W  address of the last SPI write.
- busy  output  1  high while synchronized SS_n is low.

Behaviour:
- Reset: all registers, host_rdata, spi_MISO, spi_wr_pulse, spi_wr_addr and busy are 0. State is IDLE and bit_cnt is 0.
- Input synchronization:
  - SCLK, MOSI and SS_n each pass through SYNC_STAGES flops.
  - Edges are detected against one more history flop.
  - A pin event is therefore acted on SYNC_STAGES+1 clocks later.
- States: IDLE, CMD, DATA.
- IDLE -> CMD on the synchronized SS_n falling edge. In that cycle:
  - spi_MISO <= regs[STAT_REG][7]
  - tx_sr <= regs[STAT_REG] << 1
  - bit_cnt <= 0
- SCLK rising edge (CMD or DATA): rx_sr <= {rx_sr[6:0], MOSI}, then bit_cnt increments.
- SCLK falling edge (CMD or DATA): spi_MISO <= tx_sr[7], then tx_sr shifts left by 1.
- Byte completes on the rising edge where bit_cnt == 7; bit_cnt returns to 0.
- Completing byte in CMD:
  - addr <= byte[7:3]; wr_mode <= byte[1]; bits 2 and 0 are ignored.
  - tx_sr <= regs[byte[7:3]].
  - Next state is DATA.
- Completing byte in DATA with wr_mode = 1:
  - regs[addr] <= byte; spi_wr_pulse = 1 for the next cycle; spi_wr_addr <= addr.
  - tx_sr <= regs[addr+1].
- Completing byte in DATA with wr_mode = 0:
  - tx_sr <= regs[addr+1]; no register is modified.
- After every data byte, addr increments by 1 and wraps from 2**ADDR_W-1 to 0.
- Mode 0 timing: the MSB of each outgoing byte is on MISO before the first rising edge of that byte. This holds because the load occurs on the preceding rising edge and the output on the following falling edge.
- SS_n rising edge, in any state and at any bit_cnt:
  - Go to IDLE; discard any partial byte (no write).
  - spi_MISO <= 0.
- spi_MISO stays 0 in IDLE. The output is never tristated; the top level owns tristating.
- busy = (state != IDLE).
- Host port: on host_we, regs[host_addr] <= host_wdata. host_rdata <= regs[host_addr] every cycle (1-clock latency).
- Collision (SPI write and host_we to the same address in the same cycle): SPI data wins. Writes to different addresses both commit.
- A read's data is snapshotted at the tx_sr load. Later writes to that register do not alter a byte already being shifted.
- SCLK edges while in IDLE are ignored.
- Asynchronous reset mid-transfer returns everything to reset values immediately. The transfer in progress is not resumed.

Test Plan:
- Write burst: host writes regs[0]=8'hA5. SPI sends 8'h52 (reg 10, write), 8'h11, 8'h22. Required: MISO returns 8'hA5 during the command byte; regs[10]=8'h11, regs[11]=8'h22; two spi_wr_pulse strobes with spi_wr_addr 10 then 11.
- Read burst: host preloads regs[3]=8'h3C, regs[4]=8'hC3. SPI sends 8'h18 (reg 3, read), 8'h00, 8'h00. Required: MISO bytes are stat, 8'h3C, 8'hC3; no spi_wr_pulse.
- Wrap: write command to reg 31 with data 8'h01, 8'h02. Required: regs[31]=8'h01, regs[0]=8'h02, and STAT changes accordingly on the next transfer.
- Abort: SS_n rises after 5 bits of the first data byte of a write to reg 7. Required: regs[7] unchanged, no pulse, busy drops, MISO=0; the next transfer behaves normally.
- Collision: SPI write of 8'h55 to reg 2 completes in the same cycle as host_we writing 8'hAA to reg 2. Required: regs[2]=8'h55, and host_rdata shows 8'h55 two cycles later.
- Reset: assert reset_reset_n low mid-byte. Required: all outputs 0 and regs cleared in the same cycle; a subsequent write transaction works.

Source files
------------

// File: rtl/spi_regfile_responder_if.sv
// rtl/spi_regfile_responder_if.sv - SPI pin and host register-port bundle for spi_regfile_responder
interface spi_regfile_responder_if #(
    parameter int ADDR_W = 5
);
    logic              spi_SCLK;
    logic              spi_MOSI;
    logic              spi_SS_n;
    logic              spi_MISO;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic              host_we;
    logic [7:0]        host_rdata;
    logic              spi_wr_pulse;
    logic [ADDR_W-1:0] spi_wr_addr;
    logic              busy;

    modport slave (
        input  spi_SCLK, spi_MOSI, spi_SS_n, host_addr, host_wdata, host_we,
        output spi_MISO, host_rdata, spi_wr_pulse, spi_wr_addr, busy
    );

    modport master (
        output spi_SCLK, spi_MOSI, spi_SS_n, host_addr, host_wdata, host_we,
        input  spi_MISO, host_rdata, spi_wr_pulse, spi_wr_addr, busy
    );
endinterface

// File: rtl/spi_regfile_responder.sv
// rtl/spi_regfile_responder.sv - SPI mode-0 target exposing a dual-ported 8-bit register file
module spi_regfile_responder #(
    parameter int ADDR_W      = 5,
    parameter int STAT_REG    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    spi_regfile_responder_if.slave bus
);
    localparam int                NREGS    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] STAT_IDX = ADDR_W'(STAT_REG);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ssn_sync_q;
    logic                   sclk_hist_q, ssn_hist_q;
    logic [7:0]             regs_q [NREGS];
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_sr_q, rx_sr_d;
    logic [7:0]             tx_sr_q, tx_sr_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic                   wr_mode_q, wr_mode_d;
    logic                   miso_q, miso_d;
    logic                   wr_pulse_q, wr_pulse_d;
    logic [7:0]             host_rdata_q;
    logic                   spi_we;

    logic                   sclk_s, mosi_s, ssn_s;
    logic                   sclk_rise, sclk_fall, ssn_rise, ssn_fall;
    logic [7:0]             rx_byte;
    logic [ADDR_W-1:0]      cmd_addr, addr_inc;

    // Edge detection compares the last sync stage against one extra history flop.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ssn_sync_q  <= '1;
            sclk_hist_q <= 1'b0;
            ssn_hist_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_MOSI};
            ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], bus.spi_SS_n};
            sclk_hist_q <= sclk_s;
            ssn_hist_q  <= ssn_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ssn_s     = ssn_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign ssn_rise  = ssn_s & ~ssn_hist_q;
    assign ssn_fall  = ~ssn_s & ssn_hist_q;

    assign rx_byte  = {rx_sr_q[6:0], mosi_s};
    assign cmd_addr = rx_byte[7 -: ADDR_W];
    assign addr_inc = addr_q + ADDR_W'(1);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            wr_mode_q  <= 1'b0;
            miso_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_mode_q  <= wr_mode_d;
            miso_q     <= miso_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        addr_d     = addr_q;
        wr_addr_d  = wr_addr_q;
        wr_mode_d  = wr_mode_q;
        miso_d     = miso_q;
        wr_pulse_d = 1'b0;
        spi_we     = 1'b0;

        if (ssn_rise) begin
            // Deselect drops any partial byte; the next select restarts at bit 0.
            state_d   = IDLE;
            miso_d    = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ssn_fall) begin
                        state_d   = CMD;
                        miso_d    = regs_q[STAT_IDX][7];
                        tx_sr_d   = regs_q[STAT_IDX] << 1;
                        bit_cnt_d = '0;
                    end
                end
                CMD, DATA: begin
                    if (sclk_rise) begin
                        rx_sr_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == CMD) begin
                                addr_d    = cmd_addr;
                                wr_mode_d = rx_byte[1];
                                tx_sr_d   = regs_q[cmd_addr];
                                state_d   = DATA;
                            end else begin
                                spi_we     = wr_mode_q;
                                wr_pulse_d = wr_mode_q;
                                if (wr_mode_q) wr_addr_d = addr_q;
                                tx_sr_d    = regs_q[addr_inc];
                                addr_d     = addr_inc;
                            end
                        end
                    end else if (sclk_fall) begin
                        miso_d  = tx_sr_q[7];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // SPI write is applied after the host write so it wins on a same-address collision.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            host_rdata_q <= '0;
        end else begin
            if (bus.host_we) regs_q[bus.host_addr] <= bus.host_wdata;
            if (spi_we)      regs_q[addr_q]        <= rx_byte;
            host_rdata_q <= regs_q[bus.host_addr];
        end
    end

    assign bus.spi_MISO     = miso_q;
    assign bus.host_rdata   = host_rdata_q;
    assign bus.spi_wr_pulse = wr_pulse_q;
    assign bus.spi_wr_addr  = wr_addr_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_spi_regfile_responder.sv
// tb/tb_spi_regfile_responder.sv - directed table-driven bench for spi_regfile_responder
module tb_spi_regfile_responder;
    localparam int ADDR_W = 5;
    localparam int HALF   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_regfile_responder_if #(.ADDR_W(ADDR_W)) bus ();

    spi_regfile_responder #(.ADDR_W(ADDR_W), .STAT_REG(0), .SYNC_STAGES(2)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] pulse_addr [$];
    always @(negedge clk) begin
        if (bus.spi_wr_pulse === 1'b1) pulse_addr.push_back(bus.spi_wr_addr);
    end

    typedef struct {
        string       name;
        logic [23:0] tx;
        logic [23:0] exp_rx;
        int          exp_pulses;
        logic [9:0]  exp_paddr;
        logic [9:0]  chk_a;
        logic [15:0] chk_d;
    } vec_t;

    vec_t vecs [5];

    bit         coll_en;
    logic [4:0] coll_addr;
    logic [7:0] coll_data;
    logic [7:0] coll_rdata;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.host_we    = 1'b1;
        @(negedge clk);
        bus.host_we    = 1'b0;
    endtask

    task automatic host_read(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.host_addr = a;
        @(negedge clk);
        d = bus.host_rdata;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit coll,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_MOSI = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], bus.spi_MISO};
            bus.spi_SCLK = 1'b1;
            if (coll && i == 7) begin
                // Host strobe lands on the same clock the synchronized last edge commits.
                repeat (2) @(negedge clk);
                bus.host_addr  = coll_addr;
                bus.host_wdata = coll_data;
                bus.host_we    = 1'b1;
                @(negedge clk);
                bus.host_we    = 1'b0;
                @(negedge clk);
                coll_rdata     = bus.host_rdata;
                repeat (HALF - 4) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            bus.spi_SCLK = 1'b0;
        end
    endtask

    task automatic spi_txn(input logic [23:0] tx, input int nbytes,
                           output logic [23:0] rx, output logic busy_seen);
        logic [7:0] b;
        rx = '0;
        bus.spi_SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        busy_seen = bus.busy;
        for (int k = 0; k < nbytes; k++) begin
            spi_bits(tx[23-8*k -: 8], 8, coll_en && (k == nbytes - 1), b);
            rx[23-8*k -: 8] = b;
        end
        repeat (HALF) @(negedge clk);
        bus.spi_SS_n = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    function automatic vec_t mk(input string name, input logic [23:0] tx, input logic [23:0] rx,
                                input int np, input logic [9:0] pa, input logic [9:0] ca,
                                input logic [15:0] cd);
        vec_t v;
        v.name = name; v.tx = tx; v.exp_rx = rx; v.exp_pulses = np;
        v.exp_paddr = pa; v.chk_a = ca; v.chk_d = cd;
        return v;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] rx;
        logic [7:0]  b, d;
        logic        bsy;
        int          base;

        bus.spi_SCLK = 1'b0; bus.spi_MOSI = 1'b0; bus.spi_SS_n = 1'b1;
        bus.host_addr = '0; bus.host_wdata = '0; bus.host_we = 1'b0;
        coll_en = 1'b0; coll_addr = '0; coll_data = '0; coll_rdata = '0;

        vecs[0] = mk("write_burst", 24'h521122, 24'hA50000, 2, {5'd10, 5'd11}, {5'd10, 5'd11}, 16'h1122);
        vecs[1] = mk("read_burst",  24'h180000, 24'hA53CC3, 0, 10'd0,          {5'd3,  5'd4},  16'h3CC3);
        vecs[2] = mk("wrap_write",  24'hFA0102, 24'hA500A5, 2, {5'd31, 5'd0},  {5'd31, 5'd0},  16'h0102);
        vecs[3] = mk("ignored_bits",24'h1D0000, 24'h023CC3, 0, 10'd0,          {5'd0,  5'd10}, 16'h0211);
        vecs[4] = mk("read_wrap",   24'hF80000, 24'h020102, 0, 10'd0,          {5'd31, 5'd1},  16'h0100);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_miso",    8'(bus.spi_MISO),     8'h00);
        check("rst_busy",    8'(bus.busy),         8'h00);
        check("rst_pulse",   8'(bus.spi_wr_pulse), 8'h00);
        check("rst_wr_addr", 8'(bus.spi_wr_addr),  8'h00);
        host_read(5'd0, d);
        check("rst_reg0",    d,                    8'h00);

        host_write(5'd0, 8'hA5);
        host_write(5'd3, 8'h3C);
        host_write(5'd4, 8'hC3);

        for (int i = 0; i < 5; i++) begin
            base = pulse_addr.size();
            spi_txn(vecs[i].tx, 3, rx, bsy);
            check({vecs[i].name, "_busy"}, 8'(bsy), 8'h01);
            for (int k = 0; k < 3; k++)
                check($sformatf("%s_rx%0d", vecs[i].name, k), rx[23-8*k -: 8], vecs[i].exp_rx[23-8*k -: 8]);
            check({vecs[i].name, "_npulse"}, 8'(pulse_addr.size() - base), 8'(vecs[i].exp_pulses));
            for (int k = 0; k < vecs[i].exp_pulses; k++)
                check($sformatf("%s_paddr%0d", vecs[i].name, k), 8'(pulse_addr[base+k]),
                      8'(vecs[i].exp_paddr[9-5*k -: 5]));
            for (int k = 0; k < 2; k++) begin
                host_read(vecs[i].chk_a[9-5*k -: 5], d);
                check($sformatf("%s_reg%0d", vecs[i].name, k), d, vecs[i].chk_d[15-8*k -: 8]);
            end
        end

        // Abort partway through the first data byte of a write to reg 7.
        host_write(5'd7, 8'hFC);
        base = pulse_addr.size();
        bus.spi_SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(8'h3A, 8, 1'b0, b);
        spi_bits(8'hFF, 5, 1'b0, b);
        repeat (4) @(negedge clk);
        check("abort_miso_pre", 8'(bus.spi_MISO), 8'h01);
        bus.spi_SS_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_busy",   8'(bus.busy),     8'h00);
        check("abort_miso",   8'(bus.spi_MISO), 8'h00);
        check("abort_npulse", 8'(pulse_addr.size() - base), 8'h00);
        host_read(5'd7, d);
        check("abort_reg7",   d, 8'hFC);
        base = pulse_addr.size();
        spi_txn(24'h3A7700, 2, rx, bsy);
        check("post_abort_rx0",    rx[23:16], 8'h02);
        check("post_abort_rx1",    rx[15:8],  8'hFC);
        check("post_abort_npulse", 8'(pulse_addr.size() - base), 8'h01);
        check("post_abort_paddr",  8'(pulse_addr[base]), 8'd7);
        host_read(5'd7, d);
        check("post_abort_reg7",   d, 8'h77);

        // Same-address collision, then different-address collision.
        coll_en = 1'b1; coll_addr = 5'd2; coll_data = 8'hAA;
        spi_txn(24'h125500, 2, rx, bsy);
        check("coll_rdata", coll_rdata, 8'h55);
        host_read(5'd2, d);
        check("coll_reg2",  d, 8'h55);
        coll_addr = 5'd9; coll_data = 8'h99;
        spi_txn(24'h126600, 2, rx, bsy);
        coll_en = 1'b0;
        check("coll2_rdata", coll_rdata, 8'h99);
        host_read(5'd2, d);
        check("coll2_reg2",  d, 8'h66);
        host_read(5'd9, d);
        check("coll2_reg9",  d, 8'h99);

        // Asynchronous reset in the middle of a data byte.
        bus.spi_SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(8'h52, 8, 1'b0, b);
        spi_bits(8'hFF, 3, 1'b0, b);
        check("pre_rst_busy", 8'(bus.busy), 8'h01);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",    8'(bus.busy),         8'h00);
        check("mid_rst_miso",    8'(bus.spi_MISO),     8'h00);
        check("mid_rst_pulse",   8'(bus.spi_wr_pulse), 8'h00);
        check("mid_rst_wr_addr", 8'(bus.spi_wr_addr),  8'h00);
        check("mid_rst_rdata",   bus.host_rdata,       8'h00);
        bus.spi_SS_n = 1'b1;
        bus.spi_SCLK = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        host_read(5'd0, d);
        check("post_rst_reg0",  d, 8'h00);
        host_read(5'd10, d);
        check("post_rst_reg10", d, 8'h00);
        base = pulse_addr.size();
        spi_txn(24'h62BE00, 2, rx, bsy);
        check("post_rst_rx0",    rx[23:16], 8'h00);
        check("post_rst_npulse", 8'(pulse_addr.size() - base), 8'h01);
        check("post_rst_paddr",  8'(pulse_addr[base]), 8'd12);
        host_read(5'd12, d);
        check("post_rst_reg12",  d, 8'hBE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
